// File: rtl/nn_layer_controller_pkg.sv
// -----------------------------------------------------------------------------
// nn_layer_controller_pkg
//   Shared definitions for the two-layer neural-network sequencer:
//     - state_t      : sequencer state enumeration
//     - DEF_*        : default geometry / pipeline constants
//     - weight_words : number of weight-memory words one run consumes
//     - run_latency  : cycles from the start sample to the ready pulse
// -----------------------------------------------------------------------------
package nn_layer_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_IN0     = 4;
    localparam int DEF_N0      = 3;
    localparam int DEF_N1      = 2;
    localparam int DEF_MAC_LAT = 1;
    localparam int DEF_AW      = 8;

    // Layer-0 weights occupy [0, IN0*N0), layer-1 weights follow directly.
    function automatic int weight_words(input int in0, input int n0, input int n1);
        return in0 * n0 + n0 * n1;
    endfunction

    // Each neuron costs CLEAR + K accumulates + MAC_LAT drain + WRITE,
    // plus one DONE cycle at the end of the run.
    function automatic int run_latency(input int in0, input int n0, input int n1,
                                       input int mac_lat);
        return weight_words(in0, n0, n1) + (n0 + n1) * (mac_lat + 2) + 1;
    endfunction

endpackage

// File: rtl/nn_step_counter.sv
// -----------------------------------------------------------------------------
// nn_step_counter
//   Loadable up-counter with a terminal-count flag.  The count saturates at
//   the terminal value, so it never wraps within a run.
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (count -> 0)
//   i_load     : synchronous load of i_load_val (has priority over i_inc)
//   i_load_val : value loaded by i_load
//   i_inc      : advance the count by one unless it is already at i_term
//   i_term     : terminal (last) count value
//   o_count    : current count
//   o_done     : high while o_count equals i_term
// -----------------------------------------------------------------------------
module nn_step_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_done
);

    logic [W-1:0] r_count;
    logic         w_at_term;

    assign w_at_term = (r_count == i_term);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !w_at_term) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = w_at_term;

endmodule

// File: rtl/nn_layer_controller.sv
// -----------------------------------------------------------------------------
// nn_layer_controller
//   Sequencer for a two-layer fully connected network computed on a single
//   MAC.  For every neuron it clears the accumulator, streams K input/weight
//   pairs (K = IN0 in layer 0, N0 in layer 1), waits MAC_LAT cycles for the
//   MAC pipeline to drain and then writes the activated result.  Weight
//   addresses run contiguously across both layers.  All strobes are driven
//   straight from flops.
//
// Parameters
//   IN0     : inputs per layer-0 neuron
//   N0      : layer-0 neurons (= inputs per layer-1 neuron)
//   N1      : layer-1 neurons
//   MAC_LAT : MAC pipeline depth in cycles (0 skips the drain state)
//   AW      : width of every address / index output
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : run request, sampled in IDLE (and in DONE for back-to-back runs)
//   mac_clr  : clear MAC accumulator
//   mac_en   : accumulate current input * weight
//   in_addr  : input index within the current layer
//   in_sel   : input source, 0 = external, 1 = layer-0 activation buffer
//   w_addr   : linear weight-memory address
//   act_wr   : write the activated MAC result
//   act_addr : neuron index written by act_wr
//   layer    : current layer
//   busy     : high in every state except IDLE
//   ready    : one-cycle run-complete pulse
// -----------------------------------------------------------------------------
module nn_layer_controller
    import nn_layer_controller_pkg::*;
#(
    parameter int IN0     = DEF_IN0,
    parameter int N0      = DEF_N0,
    parameter int N1      = DEF_N1,
    parameter int MAC_LAT = DEF_MAC_LAT,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [AW-1:0] in_addr,
    output logic          in_sel,
    output logic [AW-1:0] w_addr,
    output logic          act_wr,
    output logic [AW-1:0] act_addr,
    output logic          layer,
    output logic          busy,
    output logic          ready
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (IN0 < 1 || N0 < 1 || N1 < 1 || MAC_LAT < 0) begin : g_bad_geometry
        $error("nn_layer_controller: IN0/N0/N1 must be >= 1 and MAC_LAT >= 0");
    end

    if (AW < 1 || AW > 30 ||
        (weight_words(IN0, N0, N1) - 1) > ((2 ** AW) - 1)) begin : g_bad_aw
        $error("nn_layer_controller: AW too narrow for the weight address range");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [AW-1:0] K0_LAST = AW'(IN0 - 1);
    localparam logic [AW-1:0] K1_LAST = AW'(N0 - 1);
    localparam logic [AW-1:0] N0_LAST = AW'(N0 - 1);
    localparam logic [AW-1:0] N1_LAST = AW'(N1 - 1);

    localparam int              DLW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DLW-1:0]  DRAIN_LAST = DLW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    logic            r_layer;
    logic [AW-1:0]   r_w_addr;
    logic [DLW-1:0]  r_drain;
    logic            r_mac_clr;
    logic            r_mac_en;
    logic            r_act_wr;
    logic [AW-1:0]   r_act_addr;
    logic            r_ready;

    // ------------------------------------------------------------------
    // Counter control
    // ------------------------------------------------------------------
    logic            w_launch;
    logic            w_k_load;
    logic            w_k_inc;
    logic [AW-1:0]   w_k_term;
    logic [AW-1:0]   w_k_count;
    logic            w_k_done;
    logic            w_n_load;
    logic            w_n_inc;
    logic [AW-1:0]   w_n_term;
    logic [AW-1:0]   w_n_count;
    logic            w_n_done;

    // DONE also accepts start so a held request chains runs without an
    // intervening IDLE cycle.
    assign w_launch = start && ((r_state == IDLE) || (r_state == DONE));

    // k restarts in CLEAR so it reads 0 on the first accumulate cycle.
    assign w_k_load = (r_state == CLEAR);
    assign w_k_inc  = (r_state == ACC);
    assign w_k_term = r_layer ? K1_LAST : K0_LAST;

    // Neuron index restarts on a new run and on the layer-0 -> layer-1 hop.
    assign w_n_load = w_launch || ((r_state == WRITE) && w_n_done && !r_layer);
    assign w_n_inc  = (r_state == WRITE) && !w_n_done;
    assign w_n_term = r_layer ? N1_LAST : N0_LAST;

    nn_step_counter #(
        .W          (AW)
    ) u_k_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_k_load),
        .i_load_val ('0),
        .i_inc      (w_k_inc),
        .i_term     (w_k_term),
        .o_count    (w_k_count),
        .o_done     (w_k_done)
    );

    nn_step_counter #(
        .W          (AW)
    ) u_n_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_n_load),
        .i_load_val ('0),
        .i_inc      (w_n_inc),
        .i_term     (w_n_term),
        .o_count    (w_n_count),
        .o_done     (w_n_done)
    );

    // ------------------------------------------------------------------
    // Sequencer.  Each strobe is set on the same edge that enters the state
    // it belongs to, so strobes line up exactly with the state and are
    // mutually exclusive by construction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_layer    <= 1'b0;
            r_w_addr   <= '0;
            r_drain    <= '0;
            r_mac_clr  <= 1'b0;
            r_mac_en   <= 1'b0;
            r_act_wr   <= 1'b0;
            r_act_addr <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_mac_clr <= 1'b0;
            r_mac_en  <= 1'b0;
            r_act_wr  <= 1'b0;
            r_ready   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state   <= CLEAR;
                        r_layer   <= 1'b0;
                        r_w_addr  <= '0;
                        r_mac_clr <= 1'b1;
                    end
                end

                CLEAR: begin
                    r_state  <= ACC;
                    r_mac_en <= 1'b1;
                end

                ACC: begin
                    r_w_addr <= r_w_addr + AW'(1);
                    if (w_k_done) begin
                        if (MAC_LAT == 0) begin
                            r_state    <= WRITE;
                            r_act_wr   <= 1'b1;
                            r_act_addr <= w_n_count;
                        end else begin
                            r_state <= DRAIN;
                            r_drain <= '0;
                        end
                    end else begin
                        r_mac_en <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state    <= WRITE;
                        r_act_wr   <= 1'b1;
                        r_act_addr <= w_n_count;
                    end else begin
                        r_drain <= r_drain + DLW'(1);
                    end
                end

                WRITE: begin
                    if (w_n_done && r_layer) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                    end else begin
                        // Layer hop when layer 0 finishes; w_addr keeps running.
                        if (w_n_done) begin
                            r_layer <= 1'b1;
                        end
                        r_state   <= CLEAR;
                        r_mac_clr <= 1'b1;
                    end
                end

                DONE: begin
                    if (w_launch) begin
                        r_state   <= CLEAR;
                        r_layer   <= 1'b0;
                        r_w_addr  <= '0;
                        r_mac_clr <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mac_clr  = r_mac_clr;
    assign mac_en   = r_mac_en;
    assign in_addr  = w_k_count;
    assign in_sel   = r_layer;
    assign w_addr   = r_w_addr;
    assign act_wr   = r_act_wr;
    assign act_addr = r_act_addr;
    assign layer    = r_layer;
    assign busy     = (r_state != IDLE);
    assign ready    = r_ready;

endmodule

// File: tb/tb_nn_layer_controller.sv
module tb_nn_layer_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_s;

    logic       mac_clr, mac_en, in_sel, act_wr, layer, busy, ready;
    logic [7:0] in_addr, w_addr, act_addr;

    logic       mac_clr_s, mac_en_s, in_sel_s, act_wr_s, layer_s, busy_s, ready_s;
    logic [7:0] in_addr_s, w_addr_s, act_addr_s;

    always #5 clk = ~clk;

    nn_layer_controller #(
        .IN0(4), .N0(3), .N1(2), .MAC_LAT(1), .AW(8)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .mac_clr(mac_clr), .mac_en(mac_en), .in_addr(in_addr), .in_sel(in_sel),
        .w_addr(w_addr), .act_wr(act_wr), .act_addr(act_addr), .layer(layer),
        .busy(busy), .ready(ready)
    );

    nn_layer_controller #(
        .IN0(1), .N0(1), .N1(1), .MAC_LAT(0), .AW(8)
    ) u_small (
        .clk(clk), .rst(rst), .start(start_s),
        .mac_clr(mac_clr_s), .mac_en(mac_en_s), .in_addr(in_addr_s), .in_sel(in_sel_s),
        .w_addr(w_addr_s), .act_wr(act_wr_s), .act_addr(act_addr_s), .layer(layer_s),
        .busy(busy_s), .ready(ready_s)
    );

    int checks = 0;
    int errors = 0;

    int ready_first, ready_cnt, busy_err, excl_err;
    logic last_clr;
    int wq[$], selq[$], inq[$], aaq[$], alq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Observe cycles 1..ncyc of a run; cycle 1 is the period right after
    // the sampling edge.  mode 0: start low, 1: start toggled, 2: start held.
    task automatic watch(input int ncyc, input int mode);
        ready_first = -1; ready_cnt = 0; busy_err = 0; excl_err = 0; last_clr = 1'b0;
        wq.delete(); selq.delete(); inq.delete(); aaq.delete(); alq.delete();
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (ready === 1'b1) begin
                ready_cnt++;
                if (ready_first < 0) ready_first = c;
            end
            if (busy !== ((c <= 34) || (mode == 2))) busy_err++;
            if ((int'(mac_clr) + int'(mac_en) + int'(act_wr) + int'(ready)) > 1) excl_err++;
            if (mac_en === 1'b1) begin
                wq.push_back(int'(w_addr));
                selq.push_back(int'(in_sel));
                inq.push_back(int'(in_addr));
            end
            if (act_wr === 1'b1) begin
                aaq.push_back(int'(act_addr));
                alq.push_back(int'(layer));
            end
            last_clr = mac_clr;
            case (mode)
                1:       start = (c >= 2 && c <= 30) ? (c % 2 == 1) : 1'b0;
                2:       start = 1'b1;
                default: start = 1'b0;
            endcase
        end
    endtask

    initial begin
        int aa_exp[5];
        int al_exp[5];
        int bad;
        int sfirst, scnt, swr;

        aa_exp = '{0, 1, 2, 0, 1};
        al_exp = '{0, 0, 0, 1, 1};

        // Reset state
        rst = 1'b0; start = 1'b0; start_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", {25'd0, mac_clr, mac_en, act_wr, ready, busy, layer, in_sel}, 32'd0);
        check("reset_addrs", {8'd0, w_addr, in_addr, act_addr}, 32'd0);
        check("reset_small_busy", {31'd0, busy_s}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_release", {30'd0, busy, ready}, 32'd0);

        // Run A: one-cycle start pulse
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch(40, 0);
        check("A_ready_cycle", ready_first, 34);
        check("A_ready_count", ready_cnt, 1);
        check("A_busy_window", busy_err, 0);
        check("A_strobe_excl", excl_err, 0);
        check("A_mac_en_count", wq.size(), 18);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i] != i) bad++;
            if (selq[i] != ((i >= 12) ? 1 : 0)) bad += 100;
            if (inq[i] != ((i < 12) ? (i % 4) : ((i - 12) % 3))) bad += 10000;
        end
        check("A_waddr_insel_inaddr", bad, 0);
        check("A_act_wr_count", aaq.size(), 5);
        bad = 0;
        for (int i = 0; i < aaq.size() && i < 5; i++) begin
            if (aaq[i] != aa_exp[i]) bad++;
            if (alq[i] != al_exp[i]) bad += 100;
        end
        check("A_act_addr_layer", bad, 0);

        // Run B: start toggled while busy
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch(40, 1);
        check("B_ready_cycle", ready_first, 34);
        check("B_ready_count", ready_cnt, 1);
        check("B_busy_window", busy_err, 0);

        // Run C: start held high through DONE
        start = 1'b1;
        @(posedge clk);
        #1;
        watch(35, 2);
        start = 1'b0;
        check("C_ready_cycle", ready_first, 34);
        check("C_clear_at_35", {31'd0, last_clr}, 32'd1);
        check("C_busy_window", busy_err, 0);

        // Second run is now at its cycle 1; advance to cycle 15 and reset
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
        end
        check("R_pre_clear", {31'd0, mac_clr}, 32'd1);
        check("R_pre_waddr", {24'd0, w_addr}, 32'd8);
        #2;
        rst = 1'b0;
        #1;
        check("R_strobes_zero", {25'd0, mac_clr, mac_en, act_wr, ready, busy, layer, in_sel}, 32'd0);
        check("R_addrs_zero", {8'd0, w_addr, in_addr, act_addr}, 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0 || act_wr !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("R_quiet_in_reset", bad, 0);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch(40, 0);
        check("R_ready_cycle", ready_first, 34);
        check("R_ready_count", ready_cnt, 1);
        check("R_busy_window", busy_err, 0);
        check("R_mac_en_count", wq.size(), 18);

        // Minimal geometry, no drain state
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        sfirst = -1; scnt = 0; swr = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (ready_s === 1'b1) begin
                scnt++;
                if (sfirst < 0) sfirst = c;
            end
            if (act_wr_s === 1'b1) swr++;
        end
        check("S_ready_cycle", sfirst, 7);
        check("S_ready_count", scnt, 1);
        check("S_act_wr_count", swr, 2);
        check("S_idle_after", {31'd0, busy_s}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_layer_controller.md
NN_LAYER_CONTROLLER -- requirements
Module: nn_layer_controller

Interface
REQ-001 Parameter IN0, default 4: inputs per layer-0 neuron (>=1).
REQ-002 Parameter N0, default 3: layer-0 neuron count, also inputs per layer-1 neuron (>=1).
REQ-003 Parameter N1, default 2: layer-1 neuron count (>=1).
REQ-004 Parameter MAC_LAT, default 1: MAC pipeline depth in cycles (>=0).
REQ-005 Parameter AW, default 8: width of all address/index outputs.
REQ-006 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have the port start, input, 1 bit: run request, level-sampled in IDLE.
REQ-009 The block SHALL have the port mac_clr, output, 1 bit: clear the MAC accumulator.
REQ-010 The block SHALL have the port mac_en, output, 1 bit: accumulate the current input*weight product.
REQ-011 The block SHALL have the port in_addr, output, AW bits: input index within the current layer.
REQ-012 The block SHALL have the port in_sel, output, 1 bit: input source (0 external, 1 layer-0 activation buffer).
REQ-013 The block SHALL have the port w_addr, output, AW bits: linear weight-memory address.
REQ-014 The block SHALL have the port act_wr, output, 1 bit: write the activated MAC result.
REQ-015 The block SHALL have the port act_addr, output, AW bits: neuron index for act_wr.
REQ-016 The block SHALL have the port layer, output, 1 bit: current layer (0/1).
REQ-017 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-018 The block SHALL have the port ready, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, ACC, DRAIN, WRITE, DONE.
REQ-020 IDLE: start=1 at an edge -> CLEAR next cycle with layer=0, neuron=0, w_addr=0; start=0 -> stay.
REQ-021 CLEAR: mac_clr=1 for 1 cycle, k=0 -> ACC.
REQ-022 ACC: mac_en=1, in_addr=k, w_addr increments by 1 each ACC cycle; after K cycles (K=IN0 in layer 0, N0 in layer 1) -> DRAIN.
REQ-023 DRAIN: all strobes low for MAC_LAT cycles -> WRITE; MAC_LAT=0 skips DRAIN.
REQ-024 WRITE: act_wr=1, act_addr=neuron for 1 cycle; then last neuron of layer 0 -> layer=1, neuron=0, CLEAR; last neuron of layer 1 -> DONE; else neuron+1, CLEAR.
REQ-025 DONE: ready=1 for exactly 1 cycle -> IDLE.
REQ-026 in_sel SHALL equal layer; w_addr SHALL continue across layers without reset (layer-1 weights start at IN0*N0).
REQ-027 Per-neuron cost SHALL be K+MAC_LAT+2 cycles; total latency from start sample to ready = IN0*N0 + N0*N1 + (N0+N1)*(MAC_LAT+2) + 1 cycles.
REQ-028 start while busy SHALL be ignored; start held high through DONE SHALL launch a new run from IDLE the cycle after ready.
REQ-029 mac_clr, mac_en, act_wr, ready SHALL be mutually exclusive and registered (glitch-free).
REQ-030 Counters SHALL not wrap within a run; AW must cover IN0*N0+N0*N1-1 (checked by elaboration assertion).

Reset
REQ-031 rst=0 SHALL immediately force IDLE, all counters 0, and all outputs 0, including mid-run; no partial ready or act_wr after release.
REQ-032 After rst rises, the first start sample SHALL occur at the next rising edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration and default parameter constants for reuse by the datapath and bench.
REQ-034 One sub-module, nn_step_counter (loadable terminal-count up-counter with done flag), SHALL be used for the k and neuron counters.

Verification
REQ-035 Defaults, start pulse 1 cycle -> ready pulses once exactly 34 cycles after the sampling edge; busy high for cycles 1..34.
REQ-036 Defaults -> w_addr sequence on mac_en cycles 0..17 contiguous; in_sel=0 for first 12 mac_en, 1 for last 6.
REQ-037 Defaults -> act_wr pulses 5 times, act_addr 0,1,2 (layer=0) then 0,1 (layer=1).
REQ-038 start toggled during run -> no restart, ready still at cycle 34; start held high -> second run CLEAR at cycle 35.
REQ-039 rst low at cycle 15 -> all outputs 0 same cycle, no ready; new start after release -> full 34-cycle run.
REQ-040 MAC_LAT=0, IN0=1, N0=1, N1=1 -> ready 7 cycles after start sample.
